banco_registradores: RTL

General-purpose register file of the multicycle MIPS datapath and the consumer of the write-data selection mux. It holds 32 architectural registers, takes the selected write-data word plus a destination address and write strobe from the control unit, and drives two read ports into the A/B operand latches. Register 0 is hardwired to zero. Register 29 ($sp) initialises to 227, the same value the write-data mux can force.

---
 rtl/banco_registradores.sv | 54 +++++
 1 files changed

// File: rtl/banco_registradores.sv
// 32-entry general-purpose register file with two combinational read ports.
// Register 0 reads as zero, and the stack pointer resets to SP_INIT.
module banco_registradores #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_ADDR = 29,
  parameter int unsigned SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Next-state: a single write port; writes to register 0 are dropped.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (RegWrite && (WriteReg != '0)) begin
      regs_d[WriteReg] = WriteData;
    end
  end

  // Reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_ADDR) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write-to-read bypass: reads see pre-edge contents.
  always_comb begin
    ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];
  end

endmodule
